pim_matmul_sequencer: RTL and testbench
=======================================

# pim_matmul_sequencer

Processing-in-memory compute stage that sits directly downstream of the memory read path. It accepts two row-major square operand matrices (A, B) and a size, and computes C = A × B with a single multiply-accumulate datapath, one MAC per cycle. It presents C on a result array with a level `result_ready`, which the memory write path qualifies with its own `write_en` before storing at the destination address.

## Interface
- `WIDTH`, 32, element width in bits (operands, accumulator, result).
- `MAX_MATRIX_SIZE`, 16, largest supported dimension n.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  request a multiply; sampled on rising edge.
- `matrix_size`  in  $clog2(MAX_MATRIX_SIZE)+1  dimension n (0..MAX_MATRIX_SIZE); sampled with `start`.
- `matrix_A`  in  [MAX_MATRIX_SIZE**2][WIDTH]  operand A; element (r,c) at index r*n+c (packed by n, not by MAX).
- `matrix_B`  in  [MAX_MATRIX_SIZE**2][WIDTH]  operand B; same layout.
- `busy`  out  1  high from accepted start until result_ready rises.
- `result`  out  [MAX_MATRIX_SIZE**2][WIDTH]  C, same layout; indices ≥ n² read 0.
- `result_ready`  out  1  level; high while `result` holds a complete, valid C.

## Operation
- States: IDLE, LOAD, MAC, DONE.
- IDLE/DONE + `start`=1: latch n into the size register, clear `result_ready`, set `busy`, go to LOAD. If n > MAX_MATRIX_SIZE, clamp to MAX_MATRIX_SIZE.
- LOAD (1 cycle): copy `matrix_A` and `matrix_B` into internal operand registers, so inputs may change afterwards. Zero all `result` entries. Clear i, j, k and the accumulator. Next state is MAC, or DONE if n = 0.
- MAC: each cycle acc ← acc + A[i*n+k]·B[k*n+j].
  - k increments every cycle.
  - When k = n−1: write result[i*n+j] ← acc + product, clear acc and k, advance j. When j wraps at n−1, advance i.
  - When i = j = k = n−1: go to DONE.
- DONE: `result_ready`=1, `busy`=0. `result` is held stable until the next accepted start.
- Arithmetic: unsigned. The product and the sum are both truncated modulo 2^WIDTH; no overflow flag.
- `start` while in LOAD or MAC is ignored. The in-flight operation is unaffected.
- A new `start` in DONE drops `result_ready` on that edge and discards the previous C at LOAD.

## Timing
- Call the edge that samples `start`=1 edge E0.
- `busy` is high after E0.
- LOAD executes at E1.
- MAC executes at edges E2..E(n³+1).
- `result_ready` is high after edge E(n³+1), so latency is n³+1 cycles. For n = 0, `result_ready` is high after E1.
- Throughput: one result element every n cycles during MAC.
- Reset (`rst`=0) forces the following immediately, regardless of clock, including mid-operation:
  - state IDLE;
  - `busy`=0, `result_ready`=0;
  - all `result` entries 0;
  - counters, accumulator and operand registers 0.
- First `start` accepted on the first rising edge with `rst`=1.

## Structure
- Shared package `pim_pkg`:
  - WIDTH/MAX_MATRIX_SIZE defaults;
  - state enum typedef `pim_seq_state_e`;
  - index typedef sized $clog2(MAX_MATRIX_SIZE**2);
  - element typedef `logic [WIDTH-1:0]`.
- Sub-module `pim_mac`:
  - ports: clk, rst, `clr`, `en`, `a`, `b`, `acc`, `sum`;
  - `sum` = acc + a·b, combinational, truncated to WIDTH;
  - `acc` register updated when `en`, zeroed when `clr`.
- The top level owns the FSM, the i/j/k counters, the operand copies and the result array.

## Test plan
- n=1, A[0]=3, B[0]=4, pulse start → result[0]=12, `result_ready` high after 2 edges, `busy` low afterwards.
- n=2, A={1,2,3,4}, B={5,6,7,8} → result={19,22,43,50}, ready exactly 9 edges after start. Change inputs at E2 → result unaffected.
- n=1, A[0]=0xFFFFFFFF, B[0]=2 → result[0]=0xFFFFFFFE (modulo wrap).
- n=16, all elements 1 → every result entry 16, ready after 4097 edges. Pulse start at edge 100 → ignored, result unchanged.
- n=3 run with `rst` dropped at cycle 10 → `busy`=0, `result_ready`=0, all results 0 immediately. Restart with n=0 → ready after 1 edge, all results 0.

Source files
------------

// File: rtl/pim_matmul_sequencer_pkg.sv
// Shared types and sizing for the PIM matrix-multiply sequencer.
package pim_pkg;
    localparam int WIDTH           = 32;
    localparam int MAX_MATRIX_SIZE = 16;
    localparam int N2              = MAX_MATRIX_SIZE * MAX_MATRIX_SIZE;
    localparam int IDX_W           = $clog2(N2);
    localparam int CNT_W           = $clog2(MAX_MATRIX_SIZE);
    localparam int SIZE_W          = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} pim_seq_state_e;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [IDX_W:0]    idx_wide_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [SIZE_W-1:0] size_t;
    typedef logic [WIDTH-1:0]  elem_t;
endpackage

// File: rtl/pim_matmul_sequencer_if.sv
// Request/result bundle between the memory read/write paths and the sequencer.
interface pim_matmul_sequencer_if;
    import pim_pkg::*;

    logic  start;
    size_t matrix_size;
    elem_t matrix_A [N2];
    elem_t matrix_B [N2];
    logic  busy;
    elem_t result [N2];
    logic  result_ready;

    modport master (
        output start, matrix_size, matrix_A, matrix_B,
        input  busy, result, result_ready
    );

    modport slave (
        input  start, matrix_size, matrix_A, matrix_B,
        output busy, result, result_ready
    );
endinterface

// File: rtl/pim_matmul_sequencer_mac.sv
// Single multiply-accumulate lane; sum is the combinational next value of acc.
module pim_mac
    import pim_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  en,
    input  elem_t a,
    input  elem_t b,
    output elem_t acc,
    output elem_t sum
);
    assign sum = acc + a * b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end
endmodule

// File: rtl/pim_matmul_sequencer.sv
// Sequences C = A x B through one MAC lane, one product per cycle, k innermost.
module pim_matmul_sequencer
    import pim_pkg::*;
(
    input logic clk,
    input logic rst,
    pim_matmul_sequencer_if.slave bus
);
    pim_seq_state_e state, state_nxt;
    size_t n, n_m1;
    cnt_t  i, j, k;
    elem_t op_a [N2];
    elem_t op_b [N2];
    elem_t res  [N2];
    logic  do_start, do_load, do_mac;
    logic  last_i, last_j, last_k;
    logic  mac_clr, mac_en;
    elem_t mac_a, mac_b, mac_acc, mac_sum;
    idx_t  idx_a, idx_b, idx_c;

    function automatic size_t clamp_size(size_t s);
        return (s > size_t'(MAX_MATRIX_SIZE)) ? size_t'(MAX_MATRIX_SIZE) : s;
    endfunction

    // Operands are packed by the active n, not by MAX_MATRIX_SIZE.
    function automatic idx_t flat_idx(cnt_t row, size_t dim, cnt_t col);
        idx_wide_t t;
        t = idx_wide_t'(row) * idx_wide_t'(dim) + idx_wide_t'(col);
        return t[IDX_W-1:0];
    endfunction

    assign n_m1   = n - size_t'(1);
    assign last_i = ({1'b0, i} == n_m1);
    assign last_j = ({1'b0, j} == n_m1);
    assign last_k = ({1'b0, k} == n_m1);

    assign idx_a = flat_idx(i, n, k);
    assign idx_b = flat_idx(k, n, j);
    assign idx_c = flat_idx(i, n, j);
    assign mac_a = op_a[idx_a];
    assign mac_b = op_b[idx_b];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_load   = 1'b0;
        do_mac    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    do_start  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                do_load   = 1'b1;
                state_nxt = (n == '0) ? DONE : MAC;
            end
            MAC: begin
                do_mac = 1'b1;
                if (last_i && last_j && last_k) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The accumulator restarts at every output element boundary.
    assign mac_clr = do_load | (do_mac & last_k);
    assign mac_en  = do_mac;

    pim_mac u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (mac_a),
        .b   (mac_b),
        .acc (mac_acc),
        .sum (mac_sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n <= '0;
            i <= '0;
            j <= '0;
            k <= '0;
            for (int e = 0; e < N2; e++) begin
                op_a[e] <= '0;
                op_b[e] <= '0;
                res[e]  <= '0;
            end
        end else begin
            if (do_start) begin
                n <= clamp_size(bus.matrix_size);
            end
            if (do_load) begin
                i <= '0;
                j <= '0;
                k <= '0;
                for (int e = 0; e < N2; e++) begin
                    op_a[e] <= bus.matrix_A[e];
                    op_b[e] <= bus.matrix_B[e];
                    res[e]  <= '0;
                end
            end else if (do_mac) begin
                if (last_k) begin
                    res[idx_c] <= mac_sum;
                    k          <= '0;
                    if (last_j) begin
                        j <= '0;
                        i <= i + cnt_t'(1);
                    end else begin
                        j <= j + cnt_t'(1);
                    end
                end else begin
                    k <= k + cnt_t'(1);
                end
            end
        end
    end

    assign bus.busy         = (state == LOAD) || (state == MAC);
    assign bus.result_ready = (state == DONE);
    assign bus.result       = res;
endmodule

// File: tb/tb_pim_matmul_sequencer.sv
// Randomized bench for pim_matmul_sequencer against a matrix-level reference model.
module tb_pim_matmul_sequencer;
    import pim_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pim_matmul_sequencer_if bus();

    pim_matmul_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: tracks only what the outside world can see.
    logic  m_busy, m_ready, m_known, m_load;
    int    m_left, m_n;
    elem_t m_res [N2];
    elem_t c_tmp [N2];
    elem_t acc_tmp;

    function automatic int clampn(int s);
        return (s > MAX_MATRIX_SIZE) ? MAX_MATRIX_SIZE : s;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_known <= 1'b1;
            m_load  <= 1'b0;
            m_left  <= 0;
            for (int e = 0; e < N2; e++) m_res[e] <= '0;
        end else if (m_busy) begin
            if (m_load) begin
                for (int e = 0; e < N2; e++) c_tmp[e] = '0;
                for (int r = 0; r < m_n; r++)
                    for (int c = 0; c < m_n; c++) begin
                        acc_tmp = '0;
                        for (int t = 0; t < m_n; t++)
                            acc_tmp = acc_tmp + bus.matrix_A[r*m_n+t] * bus.matrix_B[t*m_n+c];
                        c_tmp[r*m_n+c] = acc_tmp;
                    end
                for (int e = 0; e < N2; e++) m_res[e] <= c_tmp[e];
                m_load <= 1'b0;
            end
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_known <= 1'b1;
            end
        end else if (bus.start) begin
            m_n     <= clampn(int'(bus.matrix_size));
            m_left  <= clampn(int'(bus.matrix_size)) ** 3 + 1;
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
            m_known <= 1'b0;
            m_load  <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm);
        int bad;
        bad = -1;
        for (int e = 0; e < N2; e++)
            if (bad < 0 && bus.result[e] !== m_res[e]) bad = e;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s: result[%0d] got %0h expected %0h at %0t",
                     nm, bad, bus.result[bad], m_res[bad], $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("busy", {31'b0, bus.busy}, {31'b0, m_busy});
            chk("result_ready", {31'b0, bus.result_ready}, {31'b0, m_ready});
            if (m_known) chk_all("result");
        end
    end

    task automatic fill_random();
        for (int e = 0; e < N2; e++) begin
            bus.matrix_A[e] = $urandom;
            bus.matrix_B[e] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
    endtask

    task automatic fill_const(input elem_t va, input elem_t vb);
        for (int e = 0; e < N2; e++) begin
            bus.matrix_A[e] = va;
            bus.matrix_B[e] = vb;
        end
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #2;
        bus.matrix_size = size_t'(n);
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask

    // Returns edges from the start-sampling edge until result_ready is seen.
    task automatic run_mm(input int n, input bit scramble, input int ignore_at, output int lat);
        int budget;
        pulse_start(n);
        lat = 0;
        budget = clampn(n) ** 3 + 20;
        while (!bus.result_ready && lat < budget) begin
            @(posedge clk);
            lat++;
            #2;
            if (scramble && lat == 1) fill_random();
            bus.start = (lat == ignore_at);
        end
        bus.start = 1'b0;
        if (!bus.result_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout n=%0d: result_ready low after %0d edges", n, lat);
        end
    endtask

    int lat;
    int n_r;
    int nonzero;

    initial begin
        bus.start = 1'b0;
        bus.matrix_size = '0;
        fill_const('0, '0);
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_res0", bus.result[0], 32'd0);

        fill_const('0, '0);
        bus.matrix_A[0] = 32'd3;
        bus.matrix_B[0] = 32'd4;
        run_mm(1, 1'b0, 0, lat);
        chk("n1_res0", bus.result[0], 32'd12);
        chk("n1_latency", lat, 32'd2);
        chk("n1_busy", {31'b0, bus.busy}, 32'd0);
        chk("n1_res1", bus.result[1], 32'd0);

        for (int e = 0; e < 4; e++) begin
            bus.matrix_A[e] = elem_t'(e + 1);
            bus.matrix_B[e] = elem_t'(e + 5);
        end
        run_mm(2, 1'b1, 0, lat);
        chk("n2_res0", bus.result[0], 32'd19);
        chk("n2_res1", bus.result[1], 32'd22);
        chk("n2_res2", bus.result[2], 32'd43);
        chk("n2_res3", bus.result[3], 32'd50);
        chk("n2_res4", bus.result[4], 32'd0);
        chk("n2_latency", lat, 32'd9);

        fill_const('0, '0);
        bus.matrix_A[0] = 32'hFFFF_FFFF;
        bus.matrix_B[0] = 32'd2;
        run_mm(1, 1'b0, 0, lat);
        chk("wrap_res0", bus.result[0], 32'hFFFF_FFFE);

        fill_const(32'd1, 32'd1);
        run_mm(16, 1'b0, 99, lat);
        chk("n16_latency", lat, 32'd4097);
        chk("n16_res0", bus.result[0], 32'd16);
        chk("n16_res255", bus.result[255], 32'd16);
        repeat (3) @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            n_r = $urandom_range(0, 6);
            fill_random();
            run_mm(n_r, $urandom_range(0, 1) == 1,
                   (n_r > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n_r ** 3) : 0, lat);
            chk("rand_latency", lat, n_r ** 3 + 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        fill_random();
        run_mm(23, 1'b0, 0, lat);
        chk("clamp_latency", lat, 32'd4097);

        fill_random();
        pulse_start(3);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_ready", {31'b0, bus.result_ready}, 32'd0);
        nonzero = 0;
        for (int e = 0; e < N2; e++) if (bus.result[e] !== '0) nonzero++;
        chk("rst_results_zero", nonzero, 32'd0);
        @(posedge clk); #2 rst = 1'b1;

        fill_random();
        run_mm(0, 1'b0, 0, lat);
        chk("n0_latency", lat, 32'd1);
        nonzero = 0;
        for (int e = 0; e < N2; e++) if (bus.result[e] !== '0) nonzero++;
        chk("n0_results_zero", nonzero, 32'd0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
